// File: rtl/grid_column_renderer.sv
// Grid column renderer: fetches one grid-RAM word per column and streams every
// 2-bit cell as a filled 8x8 block to the VGA plot port, one pixel per clock.
module grid_column_renderer #(
  parameter int COLS     = 16,
  parameter int ROWS     = 14,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  ram_addr,
  input  logic [27:0] ram_q,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [4:0]       LAST_COL = 5'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_DRAW  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [2:0]        py_q, py_d;
  logic [2:0]        px_q, px_d;
  logic [27:0]       colreg_q, colreg_d;
  logic [4:0]        ram_addr_q, ram_addr_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [2:0]        colour_q, colour_d;
  logic              plot_q, plot_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [1:0] cell_code(input logic [27:0] word, input logic [ROW_W-1:0] r);
    logic [27:0] shifted;
    shifted = word >> {r, 1'b0};
    return shifted[1:0];
  endfunction

  function automatic logic [2:0] palette(input logic [1:0] code);
    logic [2:0] rgb;
    case (code)
      2'b00:   rgb = 3'b000;
      2'b01:   rgb = 3'b100;
      2'b10:   rgb = 3'b010;
      2'b11:   rgb = 3'b110;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    py_d       = py_q;
    px_d       = px_q;
    colreg_d   = colreg_q;
    ram_addr_d = ram_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          col_d   = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: begin
        colreg_d = ram_q;
        row_d    = '0;
        py_d     = 3'd0;
        px_d     = 3'd0;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        // px is the fastest counter; the column ends after the last pixel of the last row.
        px_d = px_q + 3'd1;
        if (px_q != 3'd7) begin
          py_d = py_q;
        end else if (py_q != 3'd7) begin
          py_d = py_q + 3'd1;
        end else if (row_q != LAST_ROW) begin
          py_d  = 3'd0;
          row_d = row_q + ROW_ONE;
        end else if (col_q != LAST_COL) begin
          col_d   = col_q + 5'd1;
          state_d = S_ADDR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The address is presented on entry to ADDR so the RAM data is ready by LATCH.
    if (state_d == S_ADDR) begin
      ram_addr_d = col_d;
    end else begin
      ram_addr_d = ram_addr_q;
    end

    plot_d = (state_d == S_DRAW);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    if (state_d == S_DRAW) begin
      x_d      = 8'(X_ORIGIN) + 8'({col_d, 3'b000}) + {5'd0, px_d};
      y_d      = 7'(Y_ORIGIN) + 7'({row_d, 3'b000}) + {4'd0, py_d};
      colour_d = palette(cell_code(colreg_d, row_d));
    end else begin
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
    end
  end

  // State, counters, column register and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= 5'd0;
      row_q      <= '0;
      py_q       <= 3'd0;
      px_q       <= 3'd0;
      colreg_q   <= 28'd0;
      ram_addr_q <= 5'd0;
      x_q        <= 8'd0;
      y_q        <= 7'd0;
      colour_q   <= 3'd0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      py_q       <= py_d;
      px_q       <= px_d;
      colreg_q   <= colreg_d;
      ram_addr_q <= ram_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/grid_column_renderer.md
# grid_column_renderer

Downstream drawing stage for the falling-meatsquare game. On each refresh tick it reads the 16 column words from the grid RAM (32x28, one word per column, 14 cells of 2 bits each) and streams one pixel per clock to the VGA adapter's plot port. Every cell becomes a filled 8x8 block, and empty cells are painted black, so stale squares are erased in the same pass. It is the only reader of the grid RAM during a frame. The upstream falling and appearing logic must not write the RAM while `busy` is high.

## Interface
Parameters:
- `COLS`, 16, number of columns (RAM words 0..COLS-1).
- `ROWS`, 14, cells per column word (cell r = bits [2r+1:2r]).
- `X_ORIGIN`, 0, pixel x offset of column 0.
- `Y_ORIGIN`, 0, pixel y offset of row 0.

Ports:
- `CLOCK_50` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: refresh request. Sampled only in IDLE.
- `ram_addr` out 5: grid RAM read address.
- `ram_q` in 28: grid RAM read data. Valid two cycles after `ram_addr` changes.
- `x` out 8: pixel x.
- `y` out 7: pixel y.
- `colour` out 3: pixel colour {R,G,B}.
- `plot` out 1: pixel write strobe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a frame.

## Operation
- States: IDLE, ADDR, WAIT, LATCH, DRAW, DONE.
- IDLE:
  - `start`=1 → ADDR, with column counter `col`=0.
  - `start` is ignored in all other states, including DONE.
- ADDR: `ram_addr` ← `col` → WAIT.
- WAIT: `ram_addr` is held → LATCH.
- LATCH: the 28-bit column register ← `ram_q`; counters `row`, `py`, `px` ← 0 → DRAW.
- DRAW (one pixel per cycle):
  - Pixel order: `px` is fastest (0..7), then `py` (0..7), then `row` (0..ROWS-1).
  - When `px`=`py`=7 and `row`=ROWS-1:
    - if `col`=COLS-1 → DONE;
    - else `col`←`col`+1 → ADDR.
- DONE: `done`=1 → IDLE.
- Pixel values during DRAW:
  - `x` = X_ORIGIN + `col`*8 + `px`.
  - `y` = Y_ORIGIN + `row`*8 + `py`.
  - Both are unsigned and truncated to the port widths. The defaults reach at most x=127, y=111, so no truncation occurs.
- Palette applied to the cell code (bits [2*row+1:2*row] of the column register):
  - 00 → 000 (erase)
  - 01 → 100
  - 10 → 010
  - 11 → 110
- `plot`=1 exactly in DRAW. Outside DRAW, `x`, `y` and `colour` are don't-care but must remain stable.
- `x`, `y`, `colour` and `plot` derive only from registered state. There is no combinational path from `start` or `ram_q` to any output.
- The column register is captured once per column. RAM changes after LATCH do not affect that column's pixels.
- Reset, including mid-frame:
  - next state IDLE;
  - `col`, `row`, `py`, `px` and the column register are cleared;
  - `ram_addr`=0, `plot`=0, `busy`=0, `done`=0, `x`=0, `y`=0, `colour`=0.
- Reset and `start` asserted together: reset wins.

## Timing
- `start` sampled high at edge k:
  - ADDR in cycle k+1;
  - first `plot` in cycle k+4.
- Per column: 3 overhead cycles + ROWS*64 plot cycles = 899 cycles at the defaults.
- Column c:
  - ADDR at k+1+899c;
  - DRAW from k+4+899c through k+899+899c.
- Frame, default parameters:
  - last `plot` at k+14384;
  - `done` at k+14385;
  - IDLE at k+14386, where a new `start` is accepted.
- Total plot cycles per frame: COLS*ROWS*64 = 14336. There are no gaps inside a column's DRAW run.
- Frame rate: the 2000-cycle refresh tick is shorter than a frame. Ticks arriving while `busy` is high are dropped; there is no queuing.

## Test plan
- **Reset:** hold `reset` 3 cycles with `start`=1 → `busy`, `plot`, `done`, `ram_addr`, `x`, `y` and `colour` all 0; state stays IDLE after release until a new `start`.
- **All-zero RAM:** one `start` pulse → exactly 14336 plot cycles, every (x,y) in 0..127 × 0..111 written exactly once with `colour`=000, `done` at k+14385.
- **Single cell, column 3:** word 3 = 28'h0000001, all other words 0 → `colour`=100 exactly for x=24..31, y=0..7; all other pixels 000.
- **Corner cell:** word 15 = 28'hC000000 → `colour`=110 exactly for x=120..127, y=104..111. Checks the last row, the last column and the palette entry 11.
- **Start while busy:** pulse `start` at k+500 and again in the DONE cycle → no restart and `done` still at k+14385; `start` at k+14386 begins a new frame with ADDR at k+14387.
- **Reset mid-DRAW:** assert `reset` at k+5000 → next cycle `plot`=0, `busy`=0, `ram_addr`=0; a following `start` redraws from column 0, with the first pixel at x=0, y=0.
